// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and FIFO-full status in, byte and status strobes out.
interface uart_rx_if #(
    parameter int unsigned WORD = 8
);
    logic            i_rx;
    logic            i_fifo_full;
    logic [WORD-1:0] o_data;
    logic            o_rx_done;
    logic            o_frame_error;
    logic            o_overrun;
    logic            o_busy;

    modport master (
        output i_rx, i_fifo_full,
        input  o_data, o_rx_done, o_frame_error, o_overrun, o_busy
    );

    modport slave (
        input  i_rx, i_fifo_full,
        output o_data, o_rx_done, o_frame_error, o_overrun, o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style oversampling UART receiver, LSB first, feeding a byte FIFO.
// Emits registered one-cycle strobes for good bytes, framing errors and overruns.
module uart_rx #(
    parameter int unsigned WORD       = 8,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic     i_clock,
    input  logic     i_reset,
    uart_rx_if.slave bus
);
    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SC_W    = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W    = (WORD > 1) ? $clog2(WORD) : 1;

    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_FULL = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [1:0]       r_sync;
    logic             w_rxs;

    state_t           r_state, w_state_nxt;
    logic [SC_W-1:0]  r_sc, w_sc_nxt;
    logic [BC_W-1:0]  r_bc, w_bc_nxt;
    logic [WORD-1:0]  r_shift, w_shift_nxt;
    logic [WORD-1:0]  r_data, w_data_nxt;
    logic             r_rx_done, w_rx_done_nxt;
    logic             r_frame_error, w_frame_error_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic             r_busy;

    // Free-running oversample tick generator
    assign w_tick = (r_div == DIV_W'(DIV - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)     r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + DIV_W'(1);
    end

    // Two-flop synchroniser; line idles high
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], bus.i_rx};
    end

    assign w_rxs = r_sync[1];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_sc          <= '0;
            r_bc          <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_rx_done     <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sc          <= w_sc_nxt;
            r_bc          <= w_bc_nxt;
            r_shift       <= w_shift_nxt;
            r_data        <= w_data_nxt;
            r_rx_done     <= w_rx_done_nxt;
            r_frame_error <= w_frame_error_nxt;
            r_overrun     <= w_overrun_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    // Frame sequencing; sampling points sit mid-bit, counted from mid start bit
    always_comb begin
        w_state_nxt       = r_state;
        w_sc_nxt          = r_sc;
        w_bc_nxt          = r_bc;
        w_shift_nxt       = r_shift;
        w_data_nxt        = r_data;
        w_rx_done_nxt     = 1'b0;
        w_frame_error_nxt = 1'b0;
        w_overrun_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_sc_nxt    = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_sc == SC_HALF) begin
                        w_sc_nxt = '0;
                        if (!w_rxs) begin
                            w_state_nxt = DATA;
                            w_bc_nxt    = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_sc_nxt = r_sc + SC_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_sc == SC_FULL) begin
                        w_sc_nxt    = '0;
                        w_shift_nxt = {w_rxs, r_shift[WORD-1:1]};
                        if (r_bc == BC_LAST) w_state_nxt = STOP;
                        else                 w_bc_nxt    = r_bc + BC_W'(1);
                    end else begin
                        w_sc_nxt = r_sc + SC_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_sc == SC_FULL) begin
                        w_sc_nxt = '0;
                        if (w_rxs) begin
                            w_data_nxt    = r_shift;
                            w_rx_done_nxt = 1'b1;
                            w_overrun_nxt = bus.i_fifo_full;
                            w_state_nxt   = IDLE;
                        end else begin
                            w_frame_error_nxt = 1'b1;
                            w_state_nxt       = WAIT_HIGH;
                        end
                    end else begin
                        w_sc_nxt = r_sc + SC_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rxs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_data        = r_data;
    assign bus.o_rx_done     = r_rx_done;
    assign bus.o_frame_error = r_frame_error;
    assign bus.o_overrun     = r_overrun;
    assign bus.o_busy        = r_busy;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver (8N1-style, LSB first) that sits directly upstream of the byte FIFO.
- Oversamples the serial line with an internal baud tick generator and deserialises each frame.
- Each good byte is presented on o_data with a one-cycle o_rx_done strobe, wired straight to the FIFO's i_write/i_data.
- Reports framing errors and overruns (byte completed while the FIFO is full).

Parameters:
WORD, 8, data bits per frame; matches FIFO word width
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, serial bit rate
OVERSAMPLE, 16, ticks per bit period; must be even and >= 4

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_rx  in  1  serial line, idle high, asynchronous to i_clock
i_fifo_full  in  1  o_full of downstream FIFO
o_data  out  WORD  last correctly received byte
o_rx_done  out  1  one-cycle strobe, o_data valid; drives FIFO i_write
o_frame_error  out  1  one-cycle strobe, stop bit sampled low
o_overrun  out  1  one-cycle strobe, coincident with o_rx_done while i_fifo_full=1
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high. It forces state=IDLE, all counters 0, synchroniser flops=1, shift register=0, o_data=0, and all strobes plus o_busy=0.
- Reset mid-frame abandons the frame; no strobe is emitted.
- Baud tick: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, minimum 1.
- A free-running counter 0..DIV-1 pulses tick for one clock when it wraps.
- i_rx passes through a 2-flop synchroniser (rxs); only rxs is used internally.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Sample counter sc counts ticks; bit counter bc runs 0..WORD-1.
- IDLE: rxs==0 -> START, sc=0.
- START: on tick sc++. At sc==OVERSAMPLE/2-1 (mid start bit):
  - rxs==0 -> DATA, sc=0, bc=0.
  - rxs==1 -> IDLE; glitch rejected, no strobe.
- DATA: on tick sc++. At sc==OVERSAMPLE-1 (mid bit):
  - shift rxs in at MSB, shift register right (LSB-first assembly), sc=0.
  - bc==WORD-1 -> STOP, else bc++.
- STOP: at sc==OVERSAMPLE-1:
  - rxs==1 -> o_data<=shift register, o_rx_done=1 for exactly one clock, o_overrun=i_fifo_full in the same clock, then IDLE.
  - rxs==0 -> o_frame_error=1 for one clock, o_data unchanged, no o_rx_done, then WAIT_HIGH.
- WAIT_HIGH: stays until rxs==1, then IDLE. A held-low (break) line never produces repeated frames.
- The overrun byte is still strobed. The FIFO drops it; this block does not buffer it.
- Strobes are registered. They never assert together, except o_rx_done with o_overrun.
- Latency: o_rx_done rises between (WORD+1.5) bit periods + 2 clocks and that + DIV + 3 clocks after the start-bit falling edge on i_rx.
- A new start bit is accepted the first clock after returning to IDLE. Back-to-back frames with a single stop bit must not be lost.

Test Plan:
- Config for all tests: CLK_FREQ=3_200_000, BAUD=100_000, OVERSAMPLE=16, giving DIV=2 and a 32-clock bit period.
- Frame 0xA5 with a good stop bit -> exactly one o_rx_done pulse, o_data=0xA5, o_frame_error=0, o_busy back to 0 after the stop bit.
- Back-to-back 0x00 then 0xFF, no idle gap -> two o_rx_done pulses 320 clocks apart, o_data=0x00 then 0xFF.
- i_rx low for 4 clocks then high -> no strobes; o_busy drops back to 0 within 20 clocks.
- Frame 0x3C with stop bit 0, line held low 5 bit periods, then 0x81 normal:
  - one o_frame_error pulse and no o_rx_done for 0x3C;
  - o_data keeps its previous value;
  - then one o_rx_done with o_data=0x81.
- i_fifo_full=1 during frame 0x55 -> o_rx_done and o_overrun high in the same single clock, o_data=0x55.
- Assert i_reset after 4 data bits of a frame -> outputs reset immediately, no strobe. A following full frame 0x7E is received correctly.
